bnn_output_layer: RTL
=====================

// Module: bnn_output_layer
// PURPOSE
//  Second (output) binary layer of the BNN. Consumes the hidden-neuron bit vector
//  produced by the first XNOR-popcount layer through a valid/ready handshake.
//  Evaluates NUM_CLASSES binary neurons time-multiplexed, one per cycle, and tracks
//  the argmax. Emits the winning class index and its score with output backpressure.
//  Class weights are runtime-loadable through a serial load port.
// PARAMETERS
//  NUM_HIDDEN   4   width of the hidden vector; also the width of each class weight
//  NUM_CLASSES  4   number of output neurons, evaluated sequentially
//  CLS_W        2   class index width, $clog2(NUM_CLASSES)
//  SCORE_W      3   popcount width, $clog2(NUM_HIDDEN+1)
// PORTS
//  clk          in   1           clock
//  reset        in   1           asynchronous, active-high reset
//  hid_in       in   NUM_HIDDEN  hidden-layer bit vector
//  hid_valid    in   1           hid_in valid
//  hid_ready    out  1           block accepts hid_in
//  load_en      in   1           write load_data into weights[load_ptr]
//  load_data    in   NUM_HIDDEN  class weight to load
//  class_idx    out  CLS_W       winning class
//  class_score  out  SCORE_W     popcount of the winning class
//  out_valid    out  1           class_idx/class_score valid
//  out_ready    in   1           downstream accepts the result
//  busy         out  1           high in EVAL or HOLD
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, load_ptr=0, class_idx=0, class_score=0,
//   out_valid=0, busy=0, weights[c] = one-hot (1 << (c % NUM_HIDDEN)).
//  hid_ready = (state==IDLE) && !load_en. Combinational; low whenever busy.
//  FSM:
//   IDLE: load_en=1 -> weights[load_ptr]<=load_data; load_ptr wraps NUM_CLASSES-1->0.
//    Else hid_valid&&hid_ready -> latch hid_in; cls_cnt=0; best_score=0; best_idx=0;
//    go to EVAL. load_en and hid_valid in the same cycle: load wins, no accept.
//   EVAL: one class per cycle. s = popcount(~(hid_q ^ weights[cls_cnt])), SCORE_W bits.
//    Update best if (cls_cnt==0) || (s > best_score). Strict compare, so a tie keeps
//    the lower index. At cls_cnt==NUM_CLASSES-1 -> register the result, out_valid<=1,
//    go to HOLD. load_en is ignored in EVAL and HOLD (weights are frozen).
//   HOLD: out_valid=1; class_idx/class_score stable. out_ready=1 at an edge ->
//    out_valid<=0, go to IDLE. No same-cycle re-accept: hid_ready rises the next cycle.
//  Latency: accept edge T -> out_valid high after edge T+NUM_CLASSES.
//   Throughput is at most 1 result per NUM_CLASSES+2 cycles.
//  out_ready while out_valid=0 has no effect. class_idx/class_score keep their last
//   value after handoff.
//  Reset in EVAL/HOLD aborts: result is discarded, loaded weights revert to defaults.
// TESTING (NUM_HIDDEN=4, NUM_CLASSES=4, default weights 0001/0010/0100/1000)
//  1. After reset, check outputs: class_idx=0, class_score=0, out_valid=0, busy=0,
//     hid_ready=1.
//  2. Drive hid_in=0100 with valid -> 4 cycles later out_valid=1, class_idx=2,
//     class_score=4.
//  3. Drive hid_in=0000 (every class scores 3, a tie) -> class_idx=0, class_score=3.
//  4. Load 1111,0000,1010,0101, then drive hid_in=1010 -> class_idx=2, class_score=4.
//     A 5th load of 0011 overwrites class 0; then hid_in=0011 -> class_idx=0, score=4.
//  5. Hold out_ready=0 for 6 cycles in HOLD -> out_valid and values stable,
//     hid_ready=0, load_en ignored. Then out_ready=1 -> IDLE; hid_ready=1 next cycle.
//  6. Assert reset on the 2nd EVAL cycle -> out_valid never rises, weights back to
//     defaults, load_ptr=0. Also check: load_en together with hid_valid -> load
//     happens, no accept.

Source files
------------

// File: rtl/bnn_output_layer_if.sv
// rtl/bnn_output_layer_if.sv - hidden-vector input, weight load and result handshake bundle
interface bnn_output_layer_if #(
    parameter int NUM_HIDDEN = 4,
    parameter int CLS_W      = 2,
    parameter int SCORE_W    = 3
);
    logic [NUM_HIDDEN-1:0] hid_in;
    logic                  hid_valid;
    logic                  hid_ready;
    logic                  load_en;
    logic [NUM_HIDDEN-1:0] load_data;
    logic [CLS_W-1:0]      class_idx;
    logic [SCORE_W-1:0]    class_score;
    logic                  out_valid;
    logic                  out_ready;
    logic                  busy;

    modport master (
        output hid_in, hid_valid, load_en, load_data, out_ready,
        input  hid_ready, class_idx, class_score, out_valid, busy
    );

    modport slave (
        input  hid_in, hid_valid, load_en, load_data, out_ready,
        output hid_ready, class_idx, class_score, out_valid, busy
    );
endinterface

// File: rtl/bnn_output_layer.sv
// rtl/bnn_output_layer.sv - time-multiplexed binary output layer with argmax and loadable weights
module bnn_output_layer #(
    parameter int NUM_HIDDEN  = 4,
    parameter int NUM_CLASSES = 4,
    parameter int CLS_W       = $clog2(NUM_CLASSES),
    parameter int SCORE_W     = $clog2(NUM_HIDDEN + 1)
) (
    input logic              clk,
    input logic              reset,
    bnn_output_layer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EVAL, HOLD} state_t;

    state_t                state_q, state_d;
    logic [NUM_HIDDEN-1:0] hid_q, hid_d;
    logic [NUM_HIDDEN-1:0] weights_q [NUM_CLASSES];
    logic [CLS_W-1:0]      load_ptr_q, load_ptr_d;
    logic [CLS_W-1:0]      cls_cnt_q, cls_cnt_d;
    logic [SCORE_W-1:0]    best_score_q, best_score_d;
    logic [CLS_W-1:0]      best_idx_q, best_idx_d;
    logic [CLS_W-1:0]      class_idx_q, class_idx_d;
    logic [SCORE_W-1:0]    class_score_q, class_score_d;
    logic                  out_valid_q, out_valid_d;
    logic                  load_we;
    logic [NUM_HIDDEN-1:0] xnor_v;
    logic [SCORE_W-1:0]    score;
    logic                  take_best;

    localparam logic [CLS_W-1:0] LAST_CLS = CLS_W'(NUM_CLASSES - 1);

    // Score of the class currently under evaluation; strict compare keeps the lower index on ties
    always_comb begin
        xnor_v = ~(hid_q ^ weights_q[cls_cnt_q]);
        score  = '0;
        for (int i = 0; i < NUM_HIDDEN; i++) begin
            score = score + SCORE_W'(xnor_v[i]);
        end
        take_best = (cls_cnt_q == '0) || (score > best_score_q);
    end

    // Next-state and datapath control; loads are only honoured while idle
    always_comb begin
        state_d       = state_q;
        hid_d         = hid_q;
        load_ptr_d    = load_ptr_q;
        cls_cnt_d     = cls_cnt_q;
        best_score_d  = best_score_q;
        best_idx_d    = best_idx_q;
        class_idx_d   = class_idx_q;
        class_score_d = class_score_q;
        out_valid_d   = out_valid_q;
        load_we       = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.load_en) begin
                    load_we    = 1'b1;
                    load_ptr_d = (load_ptr_q == LAST_CLS) ? '0 : load_ptr_q + CLS_W'(1);
                end else if (bus.hid_valid) begin
                    hid_d        = bus.hid_in;
                    cls_cnt_d    = '0;
                    best_score_d = '0;
                    best_idx_d   = '0;
                    state_d      = EVAL;
                end
            end
            EVAL: begin
                if (take_best) begin
                    best_score_d = score;
                    best_idx_d   = cls_cnt_q;
                end
                cls_cnt_d = cls_cnt_q + CLS_W'(1);
                if (cls_cnt_q == LAST_CLS) begin
                    class_idx_d   = take_best ? cls_cnt_q : best_idx_q;
                    class_score_d = take_best ? score : best_score_q;
                    out_valid_d   = 1'b1;
                    state_d       = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Datapath registers; reset restores the one-hot default weights
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hid_q         <= '0;
            load_ptr_q    <= '0;
            cls_cnt_q     <= '0;
            best_score_q  <= '0;
            best_idx_q    <= '0;
            class_idx_q   <= '0;
            class_score_q <= '0;
            out_valid_q   <= 1'b0;
            for (int c = 0; c < NUM_CLASSES; c++) begin
                weights_q[c] <= NUM_HIDDEN'(1) << (c % NUM_HIDDEN);
            end
        end else begin
            hid_q         <= hid_d;
            load_ptr_q    <= load_ptr_d;
            cls_cnt_q     <= cls_cnt_d;
            best_score_q  <= best_score_d;
            best_idx_q    <= best_idx_d;
            class_idx_q   <= class_idx_d;
            class_score_q <= class_score_d;
            out_valid_q   <= out_valid_d;
            if (load_we) weights_q[load_ptr_q] <= bus.load_data;
        end
    end

    assign bus.hid_ready   = (state_q == IDLE) && !bus.load_en;
    assign bus.busy        = (state_q != IDLE);
    assign bus.class_idx   = class_idx_q;
    assign bus.class_score = class_score_q;
    assign bus.out_valid   = out_valid_q;
endmodule
